// File: rtl/temp_avg_seq.sv
// Averaging sequencer around the temperature conversion FSM: issues start pulses,
// sums 2^n conversion counts per burst, and hands the averaged result to the readout.
module temp_avg_seq #(
    parameter int WIDTH        = 8,
    parameter int MAX_AVG_LOG2 = 4,
    parameter int INT_WIDTH    = 16,
    parameter int BUSY_TIMEOUT = 7
) (
    input  logic                 lfClk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [2:0]           nAvgLog2,
    input  logic [INT_WIDTH-1:0] interval,
    output logic                 convStart,
    input  logic                 convDone,
    input  logic [WIDTH-1:0]     convCycles,
    output logic [WIDTH-1:0]     result,
    output logic                 resultValid,
    input  logic                 resultReady,
    output logic                 overrun,
    output logic                 timeoutErr,
    output logic                 busy
);
    localparam int AW = WIDTH + MAX_AVG_LOG2;
    localparam int CW = MAX_AVG_LOG2 + 1;
    localparam int NW = (MAX_AVG_LOG2 > 0) ? $clog2(MAX_AVG_LOG2 + 1) : 1;
    localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_OUTPUT,
        S_WAIT_INT
    } state_t;

    state_t                state_q, state_d;
    logic [NW-1:0]         n_q, n_d;
    logic [INT_WIDTH-1:0]  int_q, int_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [INT_WIDTH-1:0]  icnt_q, icnt_d;
    logic [WIDTH-1:0]      result_q, result_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  timeout_q, timeout_d;

    logic [NW-1:0]         n_clamp;
    logic [CW-1:0]         target;

    assign n_clamp = (32'(nAvgLog2) > 32'(MAX_AVG_LOG2)) ? NW'(MAX_AVG_LOG2) : NW'(nAvgLog2);
    assign target  = CW'(1) << n_q;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        int_d     = int_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tcnt_d    = tcnt_q;
        icnt_d    = icnt_q;
        result_d  = result_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;

        // A new result written in OUTPUT overrides a same-edge consumer transfer.
        if (valid_q && resultReady) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable && convDone) begin
                    n_d     = n_clamp;
                    int_d   = interval;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!convDone) begin
                    state_d = S_WAIT_DONE;
                end else if (tcnt_q == TW'(BUSY_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (convDone) begin
                    acc_d   = acc_q + AW'(convCycles);
                    cnt_d   = cnt_q + CW'(1);
                    state_d = (cnt_d == target) ? S_OUTPUT : S_START;
                end
            end
            S_OUTPUT: begin
                result_d = WIDTH'(acc_q >> n_q);
                valid_d  = 1'b1;
                if (valid_q && !resultReady) begin
                    overrun_d = 1'b1;
                end
                icnt_d  = int_q;
                state_d = S_WAIT_INT;
            end
            S_WAIT_INT: begin
                if (icnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    icnt_d = icnt_q - INT_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge lfClk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            int_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            icnt_q    <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            int_q     <= int_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            icnt_q    <= icnt_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign convStart   = (state_q == S_START);
    assign busy        = (state_q != S_IDLE) && (state_q != S_WAIT_INT);
    assign result      = result_q;
    assign resultValid = valid_q;
    assign overrun     = overrun_q;
    assign timeoutErr  = timeout_q;

endmodule

// File: tb/tb_temp_avg_seq.sv
// Testbench for temp_avg_seq: a behavioural conversion-FSM model feeds samples and
// expected averages are computed from the logged samples.
module tb_temp_avg_seq;
    logic        lfClk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  nAvgLog2 = 3'd0;
    logic [15:0] interval = 16'd0;
    logic        convStart;
    logic        convDone = 1'b1;
    logic [7:0]  convCycles = 8'd0;
    logic [7:0]  result;
    logic        resultValid;
    logic        resultReady = 1'b1;
    logic        overrun;
    logic        timeoutErr;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int fed[$];
    int got[$];
    int starts[$];
    int preset[$];
    int valid_cnt = 0;
    int cyc = 0;
    int ph = 0;
    int model_v = 0;
    bit stuck = 1'b0;
    bit fixed_en = 1'b0;
    int fixed_val = 0;

    always #5 lfClk = ~lfClk;

    temp_avg_seq #(
        .WIDTH(8), .MAX_AVG_LOG2(4), .INT_WIDTH(16), .BUSY_TIMEOUT(7)
    ) dut (
        .lfClk(lfClk), .rst(rst), .enable(enable), .nAvgLog2(nAvgLog2),
        .interval(interval), .convStart(convStart), .convDone(convDone),
        .convCycles(convCycles), .result(result), .resultValid(resultValid),
        .resultReady(resultReady), .overrun(overrun), .timeoutErr(timeoutErr),
        .busy(busy)
    );

    // Monitor plus conversion-FSM model: start seen in cycle t -> done low in t+2, t+3, high at t+4.
    always @(negedge lfClk) begin
        #2;
        cyc++;
        if (convStart) begin
            starts.push_back(cyc);
            checks++;
            if (!convDone) begin
                errors++;
                $display("FAIL start_while_busy: convStart=1 while convDone=%0b, required convDone=1", convDone);
            end
        end
        if (resultValid) valid_cnt++;
        if (resultValid && resultReady) got.push_back(int'(result));
        if (ph != 0) begin
            ph++;
            if (ph == 3) begin
                if (preset.size() > 0) model_v = preset.pop_front();
                else if (fixed_en) model_v = fixed_val;
                else model_v = int'($urandom_range(0, 255));
                convCycles = 8'(model_v);
                fed.push_back(model_v);
                convDone = 1'b0;
            end else if (ph == 5) begin
                convDone = 1'b1;
                ph = 0;
            end
        end
        if (convStart && !stuck && ph == 0) ph = 1;
    end

    task automatic tick();
        @(negedge lfClk);
        #1;
    endtask

    task automatic clear_logs();
        fed.delete();
        got.delete();
        starts.delete();
        valid_cnt = 0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (convStart) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!busy && ph == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (12) tick();
    endtask

    function automatic int sum_fed(int base, int cnt);
        int s = 0;
        for (int i = 0; i < cnt; i++) s += fed[base + i];
        return s;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        checks++; if (convStart !== 1'b0) begin errors++; $display("FAIL reset_convStart: got %b want 0", convStart); end
        checks++; if (result !== 8'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", result); end
        checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", resultValid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeoutErr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_single();
        bit ok;
        clear_logs();
        fixed_en = 1'b1; fixed_val = 100;
        nAvgLog2 = 3'd0; interval = 16'd0; resultReady = 1'b1; enable = 1'b1;
        repeat (45) tick();
        enable = 1'b0;
        wait_idle(ok);
        fixed_en = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL single_idle: not idle within budget, want idle"); end
        checks++; if (got.size() < 4 || got.size() != fed.size()) begin
            errors++; $display("FAIL single_count: results %0d samples %0d, want >=4 and equal", got.size(), fed.size());
        end
        foreach (got[i]) begin
            checks++; if (got[i] != 100) begin errors++; $display("FAIL single_result[%0d]: got %0d want 100", i, got[i]); end
        end
        for (int k = 1; k < starts.size(); k++) begin
            checks++; if (starts[k] - starts[k-1] != 8) begin
                errors++; $display("FAIL single_gap[%0d]: got %0d want 8", k, starts[k] - starts[k-1]);
            end
        end
        checks++; if (valid_cnt != got.size()) begin errors++; $display("FAIL single_valid_len: valid cycles %0d want %0d", valid_cnt, got.size()); end
        checks++; if (overrun !== 1'b0 || timeoutErr !== 1'b0) begin
            errors++; $display("FAIL single_flags: overrun %b timeoutErr %b want 0 0", overrun, timeoutErr);
        end
        $display("test_single: %0d results", got.size());
    endtask

    task automatic test_avg4();
        bit ok;
        clear_logs();
        preset = '{10, 11, 12, 13};
        nAvgLog2 = 3'd2; interval = 16'd3; enable = 1'b1;
        wait_start(ok);
        enable = 1'b0;
        nAvgLog2 = 3'd0;
        checks++; if (!ok) begin errors++; $display("FAIL avg4_start: no convStart, want one"); end
        wait_idle(ok);
        checks++; if (got.size() != 1 || got[0] != 11) begin
            errors++; $display("FAIL avg4_result: got %0d results first %0d, want 1 result 11", got.size(), (got.size() > 0) ? got[0] : -1);
        end
        checks++; if (starts.size() != 4) begin errors++; $display("FAIL avg4_pulses: got %0d want 4", starts.size()); end
        for (int k = 1; k < starts.size(); k++) begin
            checks++; if (starts[k] - starts[k-1] != 5) begin
                errors++; $display("FAIL avg4_gap[%0d]: got %0d want 5", k, starts[k] - starts[k-1]);
            end
        end
        $display("test_avg4: result %0d", (got.size() > 0) ? got[0] : -1);
    endtask

    task automatic test_random();
        bit ok;
        int n, eff, ns, expv;
        for (int it = 0; it < 6; it++) begin
            n = int'($urandom_range(0, 7));
            eff = (n > 4) ? 4 : n;
            ns = 1 << eff;
            clear_logs();
            nAvgLog2 = 3'(n); interval = 16'($urandom_range(0, 5)); enable = 1'b1;
            wait_start(ok);
            enable = 1'b0;
            nAvgLog2 = 3'($urandom_range(0, 7));
            wait_idle(ok);
            expv = (fed.size() == ns) ? (sum_fed(0, ns) >> eff) : -1;
            checks++; if (fed.size() != ns || starts.size() != ns) begin
                errors++; $display("FAIL rand_samples[%0d]: samples %0d pulses %0d want %0d", it, fed.size(), starts.size(), ns);
            end
            checks++; if (got.size() != 1 || got[0] != expv) begin
                errors++; $display("FAIL rand_result[%0d]: got %0d results first %0d want %0d", it, got.size(), (got.size() > 0) ? got[0] : -1, expv);
            end
            $display("test_random[%0d]: n=%0d result %0d expected %0d", it, n, (got.size() > 0) ? got[0] : -1, expv);
        end
    endtask

    task automatic test_clamp();
        bit ok;
        clear_logs();
        fixed_en = 1'b1; fixed_val = 255;
        nAvgLog2 = 3'd7; interval = 16'd0; enable = 1'b1;
        wait_start(ok);
        enable = 1'b0;
        wait_idle(ok);
        fixed_en = 1'b0;
        checks++; if (starts.size() != 16) begin errors++; $display("FAIL clamp_pulses: got %0d want 16", starts.size()); end
        checks++; if (got.size() != 1 || got[0] != 255) begin
            errors++; $display("FAIL clamp_result: got %0d results first %0d want 255", got.size(), (got.size() > 0) ? got[0] : -1);
        end
        $display("test_clamp: result %0d", (got.size() > 0) ? got[0] : -1);
    endtask

    task automatic test_back_to_back();
        bit ok;
        int iv, want, expv;
        clear_logs();
        iv = int'($urandom_range(0, 6));
        nAvgLog2 = 3'd1; interval = 16'(iv); resultReady = 1'b1; enable = 1'b1;
        for (int i = 0; i < 600 && got.size() < 5; i++) tick();
        enable = 1'b0;
        wait_idle(ok);
        checks++; if (got.size() < 5 || fed.size() != 2 * got.size()) begin
            errors++; $display("FAIL b2b_count: results %0d samples %0d want >=5 and 2x", got.size(), fed.size());
        end
        for (int i = 0; i < got.size() && 2 * i + 1 < fed.size(); i++) begin
            expv = (fed[2*i] + fed[2*i+1]) >> 1;
            checks++; if (got[i] != expv) begin errors++; $display("FAIL b2b_result[%0d]: got %0d want %0d", i, got[i], expv); end
        end
        for (int k = 1; k < starts.size(); k++) begin
            want = (k % 2 == 1) ? 5 : 8 + iv;
            checks++; if (starts[k] - starts[k-1] != want) begin
                errors++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", k, starts[k] - starts[k-1], want);
            end
        end
        checks++; if (valid_cnt != got.size()) begin errors++; $display("FAIL b2b_valid_len: got %0d want %0d", valid_cnt, got.size()); end
        $display("test_back_to_back: interval %0d, %0d results", iv, got.size());
    endtask

    task automatic test_overrun();
        bit ok;
        clear_logs();
        preset = '{50, 60};
        nAvgLog2 = 3'd0; interval = 16'd0; resultReady = 1'b0; enable = 1'b1;
        for (int i = 0; i < 60 && starts.size() < 2; i++) tick();
        enable = 1'b0;
        wait_idle(ok);
        checks++; if (resultValid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", resultValid); end
        checks++; if (result !== 8'd60) begin errors++; $display("FAIL ovr_result: got %0d want 60", result); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
        resultReady = 1'b1;
        tick();
        checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL ovr_valid_fall: got %b want 0", resultValid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        checks++; if (got.size() != 1 || got[0] != 60) begin
            errors++; $display("FAIL ovr_transfer: got %0d transfers first %0d want 1 of 60", got.size(), (got.size() > 0) ? got[0] : -1);
        end
        $display("test_overrun: overrun %b result %0d", overrun, result);
    endtask

    task automatic test_timeout();
        bit ok;
        clear_logs();
        stuck = 1'b1;
        nAvgLog2 = 3'd0; interval = 16'd0; resultReady = 1'b1; enable = 1'b1;
        wait_start(ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_start: no convStart, want one"); end
        repeat (7) tick();
        checks++; if (timeoutErr !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_early: timeoutErr %b busy %b want 0 1", timeoutErr, busy);
        end
        tick();
        checks++; if (timeoutErr !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL to_flag: timeoutErr %b busy %b want 1 0", timeoutErr, busy);
        end
        tick();
        checks++; if (convStart !== 1'b1) begin errors++; $display("FAIL to_retry: convStart %b want 1", convStart); end
        stuck = 1'b0;
        enable = 1'b0;
        wait_idle(ok);
        checks++; if (got.size() != 1 || fed.size() != 1 || got[0] != fed[0]) begin
            errors++; $display("FAIL to_retry_result: got %0d results first %0d, want 1 matching sample", got.size(), (got.size() > 0) ? got[0] : -1);
        end
        checks++; if (timeoutErr !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b want 1", timeoutErr); end
        $display("test_timeout: timeoutErr %b", timeoutErr);
    endtask

    task automatic test_rst_mid();
        bit ok;
        int base, expv;
        clear_logs();
        nAvgLog2 = 3'd2; interval = 16'd0; enable = 1'b1;
        for (int i = 0; i < 60 && starts.size() < 2; i++) tick();
        rst = 1'b1;
        tick();
        checks++; if (convStart !== 1'b0) begin errors++; $display("FAIL rstmid_convStart: got %b want 0", convStart); end
        checks++; if (result !== 8'd0) begin errors++; $display("FAIL rstmid_result: got %0d want 0", result); end
        checks++; if (resultValid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", resultValid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
        checks++; if (timeoutErr !== 1'b0) begin errors++; $display("FAIL rstmid_timeout: got %b want 0", timeoutErr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        rst = 1'b0;
        wait_start(ok);
        base = fed.size();
        enable = 1'b0;
        wait_idle(ok);
        expv = (fed.size() - base == 4) ? (sum_fed(base, 4) >> 2) : -1;
        checks++; if (got.size() < 1 || got[got.size()-1] != expv) begin
            errors++; $display("FAIL rstmid_after: got %0d results last %0d want %0d", got.size(), (got.size() > 0) ? got[got.size()-1] : -1, expv);
        end
        $display("test_rst_mid: post-reset result %0d expected %0d", (got.size() > 0) ? got[got.size()-1] : -1, expv);
    endtask

    initial begin
        test_reset();
        test_single();
        test_avg4();
        test_random();
        test_clamp();
        test_back_to_back();
        test_overrun();
        test_timeout();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
